// File: rtl/ode_step_accumulator_pkg.sv
// ode_pkg: shared types and constants for the ODE step accumulator.
//   WIDTH   : data width of the state value and increments (two's complement)
//   CNT_W   : width of the step counter
//   acc_state_t : accumulator FSM state encoding
//   SAT_POS / SAT_NEG : clamp values used when ODE_ACC_SATURATE_EN is defined
package ode_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/ode_step_accumulator_if.sv
// ode_step_accumulator_if: control, increment stream and result signals
// of the ODE step accumulator.
//   master : host / upstream side (drives start, config and increments)
//   slave  : accumulator side (drives inc_ready and the result outputs)
interface ode_step_accumulator_if
    import ode_pkg::*;
#(
    parameter int DW = WIDTH,
    parameter int CW = CNT_W
);
    logic          start;
    logic [DW-1:0] init_value;
    logic [CW-1:0] step_count;
    logic          inc_valid;
    logic          inc_ready;
    logic [DW-1:0] inc_data;
    logic          inc_sub;
    logic [DW-1:0] acc_value;
    logic          busy;
    logic          done;
    logic          overflow;

    modport master (
        output start, init_value, step_count, inc_valid, inc_data, inc_sub,
        input  inc_ready, acc_value, busy, done, overflow
    );

    modport slave (
        input  start, init_value, step_count, inc_valid, inc_data, inc_sub,
        output inc_ready, acc_value, busy, done, overflow
    );

endinterface

// File: rtl/ode_step_accumulator_add_sub.sv
// add_sub_cs: combinational signed adder/subtractor.
//   in1, in2 : operands (two's complement)
//   sub      : 1 computes in1 - in2, 0 computes in1 + in2 + cin
//   cin      : carry in (add mode)
//   out      : result, wraps modulo 2^WIDTH
//   invalid  : signed overflow of the operation
module add_sub_cs #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             invalid
);

    logic [WIDTH-1:0] b_eff;
    logic             carry;

    // Subtraction is in1 + ~in2 + 1; the +1 is folded into the carry so the
    // caller can tie cin low in both modes.
    assign b_eff   = sub ? ~in2 : in2;
    assign carry   = sub | cin;
    assign out     = in1 + b_eff + {{(WIDTH-1){1'b0}}, carry};
    assign invalid = (in1[WIDTH-1] == b_eff[WIDTH-1]) && (out[WIDTH-1] != in1[WIDTH-1]);

endmodule

// File: rtl/ode_step_accumulator.sv
// ode_step_accumulator: holds the ODE state variable x and, after start,
// applies step_count signed increments (x +/- inc) from a valid/ready stream.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high
//   bus   : ode_step_accumulator_if.slave (start/config, increment stream,
//           acc_value, busy, done pulse, sticky overflow)
// Optional build macro ODE_ACC_SATURATE_EN: clamp acc on overflow instead of
// wrapping; the overflow flag behaves the same in both builds.
//
// state | meaning
// IDLE  | waiting for start, acc_value/overflow hold the last result
// ACCUM | accepting increments, inc_ready high
// DONE  | one-cycle done pulse, then back to IDLE
module ode_step_accumulator
    import ode_pkg::*;
#(
    parameter int WIDTH = ode_pkg::WIDTH,
    parameter int CNT_W = ode_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    ode_step_accumulator_if.slave bus
);

    acc_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             inc_ready_q, inc_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sum;
    logic             sum_invalid;
    logic [WIDTH-1:0] b_eff;
    logic             ovf_step;
    logic             accept;
    logic [WIDTH-1:0] acc_next;

    add_sub_cs #(.WIDTH(WIDTH)) u_add_sub (
        .in1     (acc_q),
        .in2     (bus.inc_data),
        .sub     (bus.inc_sub),
        .cin     (1'b0),
        .out     (sum),
        .invalid (sum_invalid)
    );

    // Overflow from the sign of acc, the effective addend and the result.
    assign b_eff    = bus.inc_sub ? ~bus.inc_data : bus.inc_data;
    assign ovf_step = (acc_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
    assign accept   = (state_q == ACCUM) && inc_ready_q && bus.inc_valid;

    // The adder's own overflow must agree with the locally derived one.
    always_comb begin
        assert (sum_invalid == ovf_step);
    end

`ifdef ODE_ACC_SATURATE_EN
    // Overflow only happens when both operands share a sign, so acc's sign
    // tells which rail to clamp to.
    assign acc_next = ovf_step ? (acc_q[WIDTH-1] ? SAT_NEG : SAT_POS) : sum;
`else
    assign acc_next = sum;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.init_value;
                    ovf_d   = 1'b0;
                    cnt_d   = bus.step_count;
                    state_d = (bus.step_count == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_next;
                    ovf_d = ovf_q | ovf_step;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        inc_ready_d = (state_d == ACCUM);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            inc_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            inc_ready_q <= inc_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.inc_ready = inc_ready_q;
    assign bus.acc_value = acc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;

endmodule
